// File: rtl/project_2_source.sv
// project_2_source: registered 4-input Boolean function generator.
// Four slide switches pass through a two-flop synchronizer, an optional debounce
// filter and a truth-table lookup that drives one LED.
// The default truth table lights the LED for prime switch codes.
// Optional feature macro: PROJECT_2_SOURCE_DEBOUNCE_EN. Defining it compiles in the
// debounce filter. Without it, every synchronized code is accepted directly.
module project_2_source #(
    parameter logic [15:0] MINTERMS        = 16'h28AC,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    output logic       led
);

    // DEBOUNCE_CYCLES must be in 1..2^20. Elaboration stops on an illegal value.
    if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > (1 << 20))) begin : g_bad_debounce_cycles
        $error("project_2_source: DEBOUNCE_CYCLES out of range 1..2^20");
    end

    logic [3:0] s1_q;
    logic [3:0] s2_q;
    logic [3:0] acc_q;
    logic [3:0] acc_d;
    logic       led_q;
    logic       led_d;

`ifdef PROJECT_2_SOURCE_DEBOUNCE_EN
    // Counter sized so that it can hold DEBOUNCE_CYCLES-1 with headroom. It never wraps.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       cand_q;
    logic [3:0]       cand_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Debounce: a code must stay stable on s2 for DEBOUNCE_CYCLES cycles before it is accepted.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            acc_d = cand_q;
        end
    end

    // Debounce state registers. Reset discards any count that is in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    // No filter: the synchronized code is accepted on the next edge.
    always_comb begin
        acc_d = s2_q;
    end
`endif

    // Truth-table lookup: the accepted code indexes MINTERMS directly.
    always_comb begin
        led_d = MINTERMS[acc_q];
    end

    // Synchronizer chain, accepted code and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            acc_q <= '0;
            led_q <= 1'b0;
        end else begin
            s1_q  <= sw;
            s2_q  <= s1_q;
            acc_q <= acc_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_project_2_source.sv
// Directed bench for project_2_source: reset, full code sweep, latency, glitch rejection,
// MINTERMS overrides and reset during a debounce.
module tb_project_2_source;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       led;
    logic       led_p15;
    logic       led_ff;

`ifdef PROJECT_2_SOURCE_DEBOUNCE_EN
    localparam int LAT = 4 + 3;
`else
    localparam int LAT = 3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    project_2_source dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .led  (led)
    );

    project_2_source #(.MINTERMS(16'h8000)) dut_p15 (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .led  (led_p15)
    );

    project_2_source #(.MINTERMS(16'hFFFF)) dut_ff (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .led  (led_ff)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_prime4(input int c);
        case (c)
            2, 3, 5, 7, 11, 13: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Call at the negedge right after the first edge that samples the new code.
    // The LED must be low for the next lat-1 edges and high after edge lat.
    task automatic step_rise(input string tag, input int lat);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check_eq(tag, led, (k == lat));
        end
    endtask

    initial begin
        logic seen_low;

        rst_n = 1'b0;
        sw    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("reset_led", led, 1'b0);
            check_eq("reset_led_p15", led_p15, 1'b0);
            check_eq("reset_led_ff", led_ff, 1'b0);
        end

        sw    = 4'h0;
        rst_n = 1'b1;
        wait_cycles(10);
        check_eq("post_reset_led", led, 1'b0);
        check_eq("post_reset_led_p15", led_p15, 1'b0);
        check_eq("post_reset_led_ff", led_ff, 1'b1);

        for (int c = 0; c < 16; c++) begin
            sw = 4'(c);
            wait_cycles(10);
            check_eq($sformatf("sweep_prime_%0d", c), led, is_prime4(c));
            check_eq($sformatf("sweep_p15_%0d", c), led_p15, (c == 15));
            check_eq($sformatf("sweep_ff_%0d", c), led_ff, 1'b1);
        end

        sw = 4'h0;
        wait_cycles(10);
        check_eq("latency_pre", led, 1'b0);
        sw = 4'h3;
        @(negedge clk);
        check_eq("latency_edge0", led, 1'b0);
        step_rise("latency", LAT);

        sw = 4'h2;
        wait_cycles(10);
        check_eq("glitch_pre", led, 1'b1);
        sw = 4'h4;
        wait_cycles(2);
        sw = 4'h2;
        seen_low = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (led == 1'b0) seen_low = 1'b1;
`ifdef PROJECT_2_SOURCE_DEBOUNCE_EN
            check_eq("glitch_hold", led, 1'b1);
`endif
        end
`ifndef PROJECT_2_SOURCE_DEBOUNCE_EN
        check_eq("glitch_passes", seen_low, 1'b1);
`endif
        check_eq("glitch_post", led, 1'b1);

        sw = 4'h0;
        wait_cycles(10);
        check_eq("rst_mid_pre", led, 1'b0);
        sw = 4'h5;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_mid_in_reset", led, 1'b0);
        @(negedge clk);
        check_eq("rst_mid_edge0", led, 1'b0);
        step_rise("rst_mid_rise", LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
